extension_bram_mp: RTL and testbench
====================================

EXTENSION_BRAM_MP -- requirements
Module: extension_bram_mp

Interface
REQ-001 SHALL have parameter ITEM_SIZE, default 64: word width in bits; a multiple of 8.
REQ-002 SHALL have parameter DEPTH, default 1024: number of words.
REQ-003 SHALL have parameter NUM_PORTS, default 3: number of read/write ports, 1..8.
REQ-004 SHALL derive ADDR_W = clog2(DEPTH) and BE_W = ITEM_SIZE/8; neither is user-overridable.
REQ-005 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 SHALL have port port_addr  input  NUM_PORTS*ADDR_W  per-port word address; port i at slice [i*ADDR_W +: ADDR_W].
REQ-008 SHALL have port port_din  input  NUM_PORTS*ITEM_SIZE  per-port write data.
REQ-009 SHALL have port port_be  input  NUM_PORTS*BE_W  per-port byte enables; bit b covers din bits [8b+7:8b].
REQ-010 SHALL have port port_we  input  NUM_PORTS  per-port write request.
REQ-011 SHALL have port port_dout  output  NUM_PORTS*ITEM_SIZE  per-port registered read data.
REQ-012 SHALL have port port_wr_ok  output  NUM_PORTS  per-port one-cycle pulse: write committed.
REQ-013 SHALL have port clear_start  input  1  request a zero-fill of the whole memory.
REQ-014 SHALL have port clear_busy  output  1  zero-fill in progress.
REQ-015 SHALL have port collision_clr  input  1  zero the collision counter.
REQ-016 SHALL have port collision_count  output  16  saturating count of collision cycles.

Function
REQ-017 SHALL register reads: port_dout[i] in cycle N+1 equals mem[port_addr[i]] as held before any write committed in cycle N (read-before-write).
REQ-018 SHALL return zero on port_dout for any address >= DEPTH, and SHALL drop writes to such addresses (wr_ok = 0).
REQ-019 SHALL, for a write, update only the bytes whose port_be bit is 1; a write with port_be all zero still commits and pulses wr_ok.
REQ-020 SHALL define a collision as two or more ports with we=1 and the same in-range address in one cycle.
REQ-021 SHALL resolve a collision by fixed priority: lowest port index writes; all other colliding ports are dropped with no byte merging.
REQ-022 SHALL commit all non-colliding writes in the same cycle, independent of collisions at other addresses.
REQ-023 SHALL assert port_wr_ok[i] in cycle N+1 iff port i's write committed in cycle N; otherwise 0.
REQ-024 SHALL increment collision_count by exactly 1 per cycle having at least one dropped colliding write, saturating at 0xFFFF.
REQ-025 SHALL give collision_clr priority over increment: the counter is 0 in the next cycle and that cycle's collision is not counted.
REQ-026 SHALL implement clear FSM states IDLE and CLEAR, with a clear pointer of ADDR_W bits.
REQ-027 SHALL, in IDLE with clear_start=1, go to CLEAR with pointer 0; clear_busy is 1 from the next cycle.
REQ-028 SHALL, in CLEAR, write zero to mem[pointer] and increment the pointer each cycle; after writing DEPTH-1, go to IDLE; clear_busy is 1 for exactly DEPTH cycles.
REQ-029 SHALL, while in CLEAR, drop all port writes (wr_ok=0, not counted as collisions) and keep serving reads per REQ-017.
REQ-030 SHALL ignore clear_start while in CLEAR; no restart and no pointer change.

Reset
REQ-031 SHALL, on rst_n=0, immediately force: FSM to IDLE, pointer 0, clear_busy 0, port_wr_ok 0, port_dout 0, collision_count 0.
REQ-032 SHALL not reset memory contents; a reset during CLEAR leaves words below the pointer zero and all other words unchanged.
REQ-033 SHALL resume normal operation on the first rising edge after rst_n deasserts.

Verification
REQ-034 SHALL verify: port0 writes 0xA5A5... to addr 5 with be all-ones, then port1 reads addr 5 -> port1 dout = 0xA5A5... one cycle after the read address is applied; wr_ok[0] pulses once.
REQ-035 SHALL verify: addr 7 holds 0x1111...; port2 write 0xFF.. with be=0x01 -> addr 7 = 0x1111_1111_1111_11FF.
REQ-036 SHALL verify: ports 0,1,2 write 1,2,3 to addr 9 in the same cycle -> mem[9]=1, wr_ok=3'b001, collision_count=1; repeated 0x10000 times -> count holds 0xFFFF.
REQ-037 SHALL verify: ports 0 and 1 write different addresses 3 and 4 in one cycle -> both commit, wr_ok=2'b11, count unchanged.
REQ-038 SHALL verify: clear_start with DEPTH=16 -> clear_busy high for 16 cycles, port writes dropped meanwhile, all words 0 afterwards.
REQ-039 SHALL verify: rst_n pulsed low at cycle 5 of CLEAR -> busy 0 immediately; words 0..4 are 0 and words 5..15 retain prior values.

Source files
------------

// File: rtl/extension_bram_mp.sv
// extension_bram_mp
//   Multi-port word memory with byte enables and read-before-write registered
//   reads. When several ports write the same address in one cycle, the lowest
//   port index wins and the cycle is counted in a saturating collision counter.
//   A background zero-fill engine clears the whole array on request.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   port_addr         per-port word address, port i at [i*ADDR_W +: ADDR_W]
//   port_din          per-port write data
//   port_be           per-port byte enables (bit b -> din[8b+7:8b])
//   port_we           per-port write request
//   port_dout         per-port registered read data
//   port_wr_ok        per-port one-cycle pulse: the write of the previous cycle committed
//   clear_start       request a zero-fill of the whole memory
//   clear_busy        zero-fill in progress
//   collision_clr     zero the collision counter
//   collision_count   saturating count of cycles with a dropped colliding write
module extension_bram_mp #(
  parameter int ITEM_SIZE = 64,
  parameter int DEPTH     = 1024,
  parameter int NUM_PORTS = 3,
  localparam int ADDR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int BE_W     = ITEM_SIZE / 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_PORTS*ADDR_W-1:0]    port_addr,
  input  logic [NUM_PORTS*ITEM_SIZE-1:0] port_din,
  input  logic [NUM_PORTS*BE_W-1:0]      port_be,
  input  logic [NUM_PORTS-1:0]           port_we,
  output logic [NUM_PORTS*ITEM_SIZE-1:0] port_dout,
  output logic [NUM_PORTS-1:0]           port_wr_ok,
  input  logic                           clear_start,
  output logic                           clear_busy,
  input  logic                           collision_clr,
  output logic [15:0]                    collision_count
);

  typedef enum logic {IDLE, CLEAR} state_t;

  // One extra bit so the range check also works for non-power-of-two depths.
  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_C  = ADDR_W'(DEPTH - 1);

  logic [ITEM_SIZE-1:0] mem [DEPTH];

  state_t                       state_reg;
  logic [ADDR_W-1:0]            clr_ptr_reg;
  logic                         clear_busy_reg;
  logic [NUM_PORTS*ITEM_SIZE-1:0] dout_reg;
  logic [NUM_PORTS-1:0]         wr_ok_reg;
  logic [15:0]                  count_reg;

  logic [ADDR_W-1:0]    addr_a   [NUM_PORTS];
  logic [NUM_PORTS-1:0] in_range;
  logic [NUM_PORTS-1:0] req_valid;
  logic [NUM_PORTS-1:0] dropped;
  logic [NUM_PORTS-1:0] commit;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
      assign addr_a[gi]    = port_addr[gi*ADDR_W +: ADDR_W];
      assign in_range[gi]  = ({1'b0, addr_a[gi]} < DEPTH_C);
      // Port writes are locked out entirely while the zero-fill runs.
      assign req_valid[gi] = port_we[gi] & in_range[gi] & (state_reg == IDLE);
    end
  endgenerate

  // A port is dropped when any lower-indexed valid port targets the same word.
  always_comb begin
    dropped = '0;
    for (int i = 1; i < NUM_PORTS; i++) begin
      for (int j = 0; j < i; j++) begin
        if (req_valid[i] && req_valid[j] && (addr_a[j] == addr_a[i])) begin
          dropped[i] = 1'b1;
        end
      end
    end
  end

  assign commit = req_valid & ~dropped;

  // Memory array: no reset, so an interrupted clear leaves partial results.
  // Committed port addresses are always distinct, and port writes never
  // coincide with the clear write, so there is no write-write overlap.
  always_ff @(posedge clk) begin
    if (state_reg == CLEAR) begin
      mem[clr_ptr_reg] <= '0;
    end
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (commit[i]) begin
        for (int b = 0; b < BE_W; b++) begin
          if (port_be[i*BE_W + b]) begin
            mem[addr_a[i]][b*8 +: 8] <= port_din[i*ITEM_SIZE + b*8 +: 8];
          end
        end
      end
    end
  end

  // Registered reads see the pre-write contents (read-before-write).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_reg  <= '0;
      wr_ok_reg <= '0;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        dout_reg[i*ITEM_SIZE +: ITEM_SIZE] <= in_range[i] ? mem[addr_a[i]] : '0;
      end
      wr_ok_reg <= commit;
    end
  end

  // Collision counter: clear beats increment, saturates at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (collision_clr) begin
      count_reg <= '0;
    end else if ((|dropped) && (count_reg != 16'hFFFF)) begin
      count_reg <= count_reg + 16'd1;
    end
  end

  // Zero-fill FSM: one word per cycle, DEPTH cycles total.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      clr_ptr_reg    <= '0;
      clear_busy_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (clear_start) begin
            state_reg      <= CLEAR;
            clr_ptr_reg    <= '0;
            clear_busy_reg <= 1'b1;
          end
        end
        CLEAR: begin
          if (clr_ptr_reg == LAST_C) begin
            state_reg      <= IDLE;
            clr_ptr_reg    <= '0;
            clear_busy_reg <= 1'b0;
          end else begin
            clr_ptr_reg <= clr_ptr_reg + 1'b1;
          end
        end
        default: begin
          state_reg      <= IDLE;
          clr_ptr_reg    <= '0;
          clear_busy_reg <= 1'b0;
        end
      endcase
    end
  end

  assign port_dout       = dout_reg;
  assign port_wr_ok      = wr_ok_reg;
  assign clear_busy      = clear_busy_reg;
  assign collision_count = count_reg;

endmodule

// File: tb/tb_extension_bram_mp.sv
module tb_extension_bram_mp;

  localparam int IS = 64;
  localparam int DP = 16;
  localparam int NP = 3;
  localparam int AW = 4;
  localparam int BW = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NP*AW-1:0] port_addr;
  logic [NP*IS-1:0] port_din;
  logic [NP*BW-1:0] port_be;
  logic [NP-1:0]    port_we;
  logic [NP*IS-1:0] port_dout;
  logic [NP-1:0]    port_wr_ok;
  logic             clear_start;
  logic             clear_busy;
  logic             collision_clr;
  logic [15:0]      collision_count;

  int checks = 0;
  int passes = 0;

  extension_bram_mp #(.ITEM_SIZE(IS), .DEPTH(DP), .NUM_PORTS(NP)) dut (
    .clk(clk), .rst_n(rst_n),
    .port_addr(port_addr), .port_din(port_din), .port_be(port_be),
    .port_we(port_we), .port_dout(port_dout), .port_wr_ok(port_wr_ok),
    .clear_start(clear_start), .clear_busy(clear_busy),
    .collision_clr(collision_clr), .collision_count(collision_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int p, input logic we, input int a,
                       input logic [63:0] d, input logic [7:0] be);
    port_we[p]           = we;
    port_addr[p*AW +: AW] = a[AW-1:0];
    port_din[p*IS +: IS] = d;
    port_be[p*BW +: BW]  = be;
  endtask

  task automatic idle();
    port_we = '0;
  endtask

  function automatic logic [63:0] dout_of(input int p);
    return port_dout[p*IS +: IS];
  endfunction

  task automatic rd(input int a, output logic [63:0] v);
    drive(0, 1'b0, a, 64'h0, 8'h00);
    step();
    v = dout_of(0);
  endtask

  logic [63:0] v;
  logic [63:0] fill_val;
  int busy_cycles;
  logic wr_seen;

  initial begin
    rst_n = 1'b0; port_addr = '0; port_din = '0; port_be = '0; port_we = '0;
    clear_start = 1'b0; collision_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_dout", 64'(port_dout[63:0] | port_dout[127:64] | port_dout[191:128]), 64'h0);
    check("reset_wr_ok", 64'(port_wr_ok), 64'h0);
    check("reset_count", 64'(collision_count), 64'h0);
    check("reset_busy", 64'(clear_busy), 64'h0);
    rst_n = 1'b1;
    step();

    // Full-word write on port 0, read back on port 1.
    drive(0, 1'b1, 5, {8{8'hA5}}, 8'hFF);
    step(); idle();
    check("wr_ok_a5", 64'(port_wr_ok), 64'h1);
    drive(1, 1'b0, 5, 64'h0, 8'h00);
    step();
    check("p1_read_a5", dout_of(1), {8{8'hA5}});
    check("wr_ok_a5_once", 64'(port_wr_ok), 64'h0);

    // Byte-enable partial write.
    drive(0, 1'b1, 7, {8{8'h11}}, 8'hFF);
    step(); idle();
    drive(2, 1'b1, 7, {8{8'hFF}}, 8'h01);
    step(); idle();
    check("wr_ok_be01", 64'(port_wr_ok), 64'h4);
    rd(7, v);
    check("addr7_be01", v, 64'h1111_1111_1111_11FF);

    // Write with no byte enables still commits but changes nothing.
    drive(1, 1'b1, 7, 64'hDEAD_BEEF_DEAD_BEEF, 8'h00);
    step(); idle();
    check("wr_ok_be00", 64'(port_wr_ok), 64'h2);
    rd(7, v);
    check("addr7_be00", v, 64'h1111_1111_1111_11FF);

    // Two ports, different addresses: both commit, no collision.
    drive(0, 1'b1, 3, {8{8'h33}}, 8'hFF);
    drive(1, 1'b1, 4, {8{8'h44}}, 8'hFF);
    step(); idle();
    check("wr_ok_diff", 64'(port_wr_ok), 64'h3);
    check("count_diff", 64'(collision_count), 64'h0);

    // Read-before-write: port 2 writes addr 3 while ports 0 and 2 read it.
    drive(0, 1'b0, 3, 64'h0, 8'h00);
    drive(1, 1'b0, 4, 64'h0, 8'h00);
    drive(2, 1'b1, 3, {8{8'h99}}, 8'hFF);
    step(); idle();
    check("rbw_p0_addr3", dout_of(0), {8{8'h33}});
    check("rbw_p1_addr4", dout_of(1), {8{8'h44}});
    check("rbw_p2_addr3", dout_of(2), {8{8'h33}});
    check("wr_ok_rbw", 64'(port_wr_ok), 64'h4);
    rd(3, v);
    check("addr3_after", v, {8{8'h99}});

    // Three-way collision at addr 9.
    drive(0, 1'b1, 9, 64'd1, 8'hFF);
    drive(1, 1'b1, 9, 64'd2, 8'hFF);
    drive(2, 1'b1, 9, 64'd3, 8'hFF);
    step(); idle();
    check("wr_ok_coll", 64'(port_wr_ok), 64'h1);
    check("count_coll", 64'(collision_count), 64'h1);
    rd(9, v);
    check("addr9_coll", v, 64'd1);

    // Clear wins over a simultaneous collision.
    drive(0, 1'b1, 9, 64'd1, 8'hFF);
    drive(1, 1'b1, 9, 64'd2, 8'hFF);
    drive(2, 1'b1, 9, 64'd3, 8'hFF);
    collision_clr = 1'b1;
    step();
    collision_clr = 1'b0;
    check("count_clr_prio", 64'(collision_count), 64'h0);

    // Saturation: 0x10000 collision cycles from zero.
    repeat (32'h10000) @(posedge clk);
    #1;
    check("count_sat", 64'(collision_count), 64'hFFFF);
    step();
    check("count_sat_hold", 64'(collision_count), 64'hFFFF);
    idle();
    collision_clr = 1'b1;
    step();
    collision_clr = 1'b0;
    check("count_cleared", 64'(collision_count), 64'h0);

    // Zero-fill of the whole memory.
    for (int k = 0; k < DP; k++) begin
      fill_val = {8{8'(8'h10 + k)}};
      drive(0, 1'b1, k, fill_val, 8'hFF);
      step();
    end
    idle();
    clear_start = 1'b1;
    step();
    clear_start = 1'b0;
    busy_cycles = clear_busy ? 1 : 0;
    wr_seen = 1'b0;
    for (int n = 0; n < 40 && clear_busy; n++) begin
      drive(0, 1'b1, n % DP, {8{8'hFF}}, 8'hFF);
      drive(1, 1'b1, n % DP, {8{8'hEE}}, 8'hFF);
      clear_start = (n == 3);
      step();
      wr_seen = wr_seen | (|port_wr_ok);
      if (clear_busy) busy_cycles++;
    end
    idle();
    clear_start = 1'b0;
    check("clear_busy_cycles", 64'(busy_cycles), 64'd16);
    check("clear_wr_dropped", 64'(wr_seen), 64'h0);
    check("clear_no_coll", 64'(collision_count), 64'h0);
    for (int k = 0; k < DP; k++) begin
      rd(k, v);
      check($sformatf("clear_word%0d", k), v, 64'h0);
    end

    // Reset in the middle of a clear.
    for (int k = 0; k < DP; k++) begin
      fill_val = {8{8'(8'h20 + k)}};
      drive(0, 1'b1, k, fill_val, 8'hFF);
      step();
    end
    idle();
    clear_start = 1'b1;
    step();
    clear_start = 1'b0;
    repeat (5) step();
    check("busy_before_rst", 64'(clear_busy), 64'h1);
    rst_n = 1'b0;
    #1;
    check("rst_busy", 64'(clear_busy), 64'h0);
    check("rst_dout0", dout_of(0), 64'h0);
    check("rst_wr_ok", 64'(port_wr_ok), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < DP; k++) begin
      rd(k, v);
      fill_val = (k < 5) ? 64'h0 : {8{8'(8'h20 + k)}};
      check($sformatf("rst_word%0d", k), v, fill_val);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
